// File: rtl/pb_pkg.sv
// Shared types and defaults for the pushbutton front-end feeding the 12/24-hour mode FSM.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } pb_state_e;

  localparam int DEBOUNCE_LEN_DEF = 4;
  localparam int HOLD_TICKS_DEF   = 100;
  localparam int CNT_W_DEF        = 7;

endpackage

// File: rtl/press_pulse_gen_if.sv
// Button-side signal bundle: raw button in, debounced level and event pulses out.
interface press_pulse_gen_if;

  logic pb_in;
  logic press_processed;
  logic long_press;
  logic pb_level;

  modport master (
    output pb_in,
    input  press_processed,
    input  long_press,
    input  pb_level
  );

  modport slave (
    input  pb_in,
    output press_processed,
    output long_press,
    output pb_level
  );

endinterface

// File: rtl/pb_debounce.sv
// Two-flop synchroniser plus N-sample shift-register debouncer; exports level and
// combinational rise/fall strobes derived purely from registered state.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
) (
  input  logic clk_100hz,
  input  logic rst,
  input  logic i_pb,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                    r_sync1;
  logic                    r_sync2;
  logic [DEBOUNCE_LEN-1:0] r_shift;
  logic                    r_level;
  logic                    w_all_ones;
  logic                    w_all_zeros;

  assign w_all_ones  = &r_shift;
  assign w_all_zeros = ~|r_shift;

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_shift <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_pb;
      r_sync2 <= r_sync1;
      r_shift <= {r_shift[DEBOUNCE_LEN-2:0], r_sync2};
      // Mixed samples mean the contact is still bouncing: keep the old level.
      if (w_all_ones) begin
        r_level <= 1'b1;
      end else if (w_all_zeros) begin
        r_level <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_all_ones & ~r_level;
  assign o_fall  = w_all_zeros & r_level;

endmodule

// File: rtl/press_pulse_gen.sv
// Press / long-press pulse generator for the mode toggle FSM.
//   state   | meaning
//   IDLE    | button released, waiting for a debounced rise
//   PRESSED | press reported, counting hold time
//   HELD    | long press reported, waiting for release
module press_pulse_gen
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk_100hz,
  input  logic              rst,
  press_pulse_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pb_state_e        r_state;
  pb_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_long;
  logic             w_long_nxt;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;

  pb_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_debounce (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .i_pb      (bus.pb_in),
    .o_level   (w_level),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
      r_long  <= w_long_nxt;
    end
  end

  // Release is tested before terminal count so a release landing on the
  // terminal edge suppresses the long-press pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_TC) begin
          w_state_nxt = HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.press_processed = r_press;
  assign bus.long_press      = r_long;
  assign bus.pb_level        = w_level;

endmodule

// File: tb/tb_press_pulse_gen.sv
// Scoreboard bench: stimulus queues expected event edges, a negedge monitor pops and compares.
module tb_press_pulse_gen;

  typedef struct {
    int   e;
    logic v;
  } lvl_ev_t;

  logic clk_100hz = 1'b0;
  logic rst       = 1'b0;
  int   edge_n    = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;

  int      q_press[$];
  int      q_long[$];
  lvl_ev_t q_lvl[$];

  press_pulse_gen_if ifc ();

  press_pulse_gen #(
    .DEBOUNCE_LEN (4),
    .HOLD_TICKS   (100),
    .CNT_W        (7)
  ) dut (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .bus       (ifc)
  );

  always #5 clk_100hz = ~clk_100hz;

  always @(posedge clk_100hz) edge_n <= edge_n + 1;

  task automatic wait_neg(input int e);
    while (edge_n < e) @(negedge clk_100hz);
  endtask

  // Value v is first sampled by the DUT at edge e.
  task automatic set_at(input int e, input logic v);
    wait_neg(e - 1);
    ifc.pb_in = v;
  endtask

  task automatic exp_lvl(input int e, input logic v);
    lvl_ev_t ev;
    ev.e = e;
    ev.v = v;
    q_lvl.push_back(ev);
  endtask

  task automatic check_quiet(input string name);
    n_chk++;
    if (ifc.press_processed === 1'b0 && ifc.long_press === 1'b0 && ifc.pb_level === 1'b0)
      n_pass++;
    else
      $display("FAIL %s: press=%b long=%b level=%b, required all 0",
               name, ifc.press_processed, ifc.long_press, ifc.pb_level);
  endtask

  task automatic check_empty(input string name, input int sz);
    n_chk++;
    if (sz == 0) n_pass++;
    else $display("FAIL %s: %0d expected events never seen, required 0", name, sz);
  endtask

  // Monitor: every pulse or level change is matched against the head of its queue.
  initial begin
    logic    prev_lvl;
    int      exp_e;
    lvl_ev_t ev;
    prev_lvl = 1'b0;
    forever begin
      @(negedge clk_100hz);
      if (ifc.press_processed === 1'b1 || ifc.long_press === 1'b1) begin
        n_chk++;
        if (!(ifc.press_processed === 1'b1 && ifc.long_press === 1'b1)) n_pass++;
        else $display("FAIL exclusive: both pulses high at edge %0d", edge_n);
      end
      if (ifc.press_processed === 1'b1) begin
        n_chk++;
        if (q_press.size() == 0) begin
          $display("FAIL press_extra: pulse at edge %0d, required none", edge_n);
        end else begin
          exp_e = q_press.pop_front();
          if (exp_e == edge_n) n_pass++;
          else $display("FAIL press_edge: pulse at edge %0d, required edge %0d", edge_n, exp_e);
        end
      end
      if (ifc.long_press === 1'b1) begin
        n_chk++;
        if (q_long.size() == 0) begin
          $display("FAIL long_extra: pulse at edge %0d, required none", edge_n);
        end else begin
          exp_e = q_long.pop_front();
          if (exp_e == edge_n) n_pass++;
          else $display("FAIL long_edge: pulse at edge %0d, required edge %0d", edge_n, exp_e);
        end
      end
      if (ifc.pb_level !== prev_lvl) begin
        n_chk++;
        if (q_lvl.size() == 0) begin
          $display("FAIL level_extra: level -> %b at edge %0d, required no change",
                   ifc.pb_level, edge_n);
        end else begin
          ev = q_lvl.pop_front();
          if (ev.e == edge_n && ev.v === ifc.pb_level) n_pass++;
          else $display("FAIL level_edge: level -> %b at edge %0d, required %b at edge %0d",
                        ifc.pb_level, edge_n, ev.v, ev.e);
        end
        prev_lvl = ifc.pb_level;
      end
    end
  end

  initial begin
    ifc.pb_in = 1'b0;
    wait_neg(3);
    check_quiet("reset_state");
    rst = 1'b1;

    // Clean press, 30 cycles
    q_press.push_back(16);
    exp_lvl(16, 1'b1);
    exp_lvl(46, 1'b0);
    set_at(10, 1'b1);
    set_at(40, 1'b0);

    // Bounce 1,0,1,1,0 then stable 1 from edge 115
    q_press.push_back(121);
    exp_lvl(121, 1'b1);
    exp_lvl(146, 1'b0);
    set_at(110, 1'b1);
    set_at(111, 1'b0);
    set_at(112, 1'b1);
    set_at(114, 1'b0);
    set_at(115, 1'b1);
    set_at(140, 1'b0);

    // Long hold, 150 cycles
    q_press.push_back(216);
    q_long.push_back(316);
    exp_lvl(216, 1'b1);
    exp_lvl(366, 1'b0);
    set_at(210, 1'b1);
    set_at(360, 1'b0);

    // Release lands on the terminal-count edge, then a normal press
    q_press.push_back(416);
    exp_lvl(416, 1'b1);
    exp_lvl(516, 1'b0);
    q_press.push_back(536);
    exp_lvl(536, 1'b1);
    exp_lvl(551, 1'b0);
    set_at(410, 1'b1);
    set_at(510, 1'b0);
    set_at(530, 1'b1);
    set_at(545, 1'b0);

    // Reset for 3 cycles while held in PRESSED
    q_press.push_back(616);
    exp_lvl(616, 1'b1);
    exp_lvl(621, 1'b0);
    q_press.push_back(630);
    exp_lvl(630, 1'b1);
    exp_lvl(656, 1'b0);
    set_at(610, 1'b1);
    wait_neg(620);
    #2 rst = 1'b0;
    #1 check_quiet("reset_mid_press");
    wait_neg(623);
    rst = 1'b1;
    set_at(650, 1'b0);

    // Two presses 20 cycles apart, 15 cycles each
    q_press.push_back(716);
    exp_lvl(716, 1'b1);
    exp_lvl(731, 1'b0);
    q_press.push_back(736);
    exp_lvl(736, 1'b1);
    exp_lvl(751, 1'b0);
    set_at(710, 1'b1);
    set_at(725, 1'b0);
    set_at(730, 1'b1);
    set_at(745, 1'b0);

    wait_neg(800);
    check_empty("press_missing", q_press.size());
    check_empty("long_missing", q_long.size());
    check_empty("level_missing", q_lvl.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
